// File: rtl/bin_count_mod.sv
// Parametrised modulo up/down counter with load, one-shot stop, terminal-count flag and wrap pulse.
// Optional prescaler on the count enable is built only when BIN_COUNT_PRESCALE_EN is defined.
module bin_count_mod #(
    parameter int WIDTH    = 8,
    parameter int MODULUS  = 256,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic             up,
    input  logic             oneshot,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    output logic [WIDTH-1:0] val,
    output logic             tc,
    output logic             wrap,
    output logic             done
);

    // MODULUS-1 always fits in WIDTH bits, so every compare stays WIDTH wide even for MODULUS = 2^WIDTH.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    typedef enum logic {
        ST_RUN,
        ST_DONE
    } state_t;

    generate
        if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
            $error("bin_count_mod: MODULUS must lie in 2..2**WIDTH");
        end
        if (PRESCALE < 1) begin : g_bad_prescale
            $error("bin_count_mod: PRESCALE must be at least 1");
        end
    endgenerate

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] next_val;
    logic             next_wrap;
    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] ld_clamped;
    logic             at_term;
    logic             qen;

`ifdef BIN_COUNT_PRESCALE_EN
    localparam int             PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre;
    logic [PW-1:0] next_pre;

    // Only the PRESCALE-th enabled cycle in RUN lets the counter step.
    assign qen = cen && (state == ST_RUN) && (pre == PRE_LAST);

    always_comb begin
        next_pre = pre;
        if (ld) begin
            next_pre = '0;
        end else if (cen && (state == ST_RUN)) begin
            next_pre = (pre == PRE_LAST) ? '0 : pre + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pre <= '0;
        end else begin
            pre <= next_pre;
        end
    end
`else
    assign qen = cen && (state == ST_RUN);
`endif

    assign term       = up ? MAX_VAL : '0;
    assign at_term    = (val == term);
    assign tc         = at_term && qen;
    assign ld_clamped = (ld_val > MAX_VAL) ? MAX_VAL : ld_val;
    assign done       = (state == ST_DONE);

    always_comb begin
        next_state = state;
        next_val   = val;
        next_wrap  = 1'b0;
        if (ld) begin
            next_val   = ld_clamped;
            next_state = ST_RUN;
        end else if (qen) begin
            if (!at_term) begin
                next_val = up ? val + WIDTH'(1) : val - WIDTH'(1);
            end else if (oneshot) begin
                next_state = ST_DONE;
            end else begin
                next_val  = up ? '0 : MAX_VAL;
                next_wrap = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_RUN;
            val   <= '0;
            wrap  <= 1'b0;
        end else begin
            state <= next_state;
            val   <= next_val;
            wrap  <= next_wrap;
        end
    end

endmodule

// File: tb/tb_bin_count_mod.sv
// Randomised bench for bin_count_mod: three instances (mod 256, mod 10, mod 2) share stimulus
// and are checked every cycle against an arithmetic reference model.
module tb_bin_count_mod;

    localparam int PRESCALE_TB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cen = 1'b0;
    logic       up = 1'b1;
    logic       oneshot = 1'b0;
    logic       ld = 1'b0;
    logic [7:0] ld_val = 8'd0;

    logic [7:0] val_a;
    logic [3:0] val_b;
    logic [1:0] val_c;
    logic       tc_a, tc_b, tc_c;
    logic       wrap_a, wrap_b, wrap_c;
    logic       done_a, done_b, done_c;

    int checks = 0;
    int failures = 0;

    int modv[3]   = '{256, 10, 2};
    int ldmask[3] = '{255, 15, 3};
    int m_val[3]  = '{0, 0, 0};
    int m_pre[3]  = '{0, 0, 0};
    bit m_wrap[3] = '{0, 0, 0};
    bit m_done[3] = '{0, 0, 0};

    always #5 clk = ~clk;

    bin_count_mod #(.WIDTH(8), .MODULUS(256), .PRESCALE(PRESCALE_TB)) dut_a (
        .clk(clk), .rst(rst), .cen(cen), .up(up), .oneshot(oneshot), .ld(ld),
        .ld_val(ld_val), .val(val_a), .tc(tc_a), .wrap(wrap_a), .done(done_a)
    );

    bin_count_mod #(.WIDTH(4), .MODULUS(10), .PRESCALE(PRESCALE_TB)) dut_b (
        .clk(clk), .rst(rst), .cen(cen), .up(up), .oneshot(oneshot), .ld(ld),
        .ld_val(ld_val[3:0]), .val(val_b), .tc(tc_b), .wrap(wrap_b), .done(done_b)
    );

    bin_count_mod #(.WIDTH(2), .MODULUS(2), .PRESCALE(PRESCALE_TB)) dut_c (
        .clk(clk), .rst(rst), .cen(cen), .up(up), .oneshot(oneshot), .ld(ld),
        .ld_val(ld_val[1:0]), .val(val_c), .tc(tc_c), .wrap(wrap_c), .done(done_c)
    );

    task automatic checkOutput(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int modelTerm(input int i);
        return up ? modv[i] - 1 : 0;
    endfunction

    // Whether counter i would take a step on the coming edge, ignoring ld/rst.
    function automatic bit modelQen(input int i);
        if (m_done[i] || !cen) return 1'b0;
`ifdef BIN_COUNT_PRESCALE_EN
        return (m_pre[i] + 1) == PRESCALE_TB;
`else
        return 1'b1;
`endif
    endfunction

    task automatic modelUpdate();
        bit q;
        int t;
        int lv;
        for (int i = 0; i < 3; i++) begin
            q  = modelQen(i);
            t  = modelTerm(i);
            lv = int'(ld_val) & ldmask[i];
            if (!rst) begin
                m_val[i] = 0; m_wrap[i] = 0; m_done[i] = 0; m_pre[i] = 0;
            end else if (ld) begin
                m_val[i]  = (lv >= modv[i]) ? modv[i] - 1 : lv;
                m_wrap[i] = 0; m_done[i] = 0; m_pre[i] = 0;
            end else begin
                m_wrap[i] = 0;
                if (!m_done[i] && cen) m_pre[i] = q ? 0 : m_pre[i] + 1;
                if (q) begin
                    if (oneshot && m_val[i] == t) begin
                        m_done[i] = 1;
                    end else begin
                        m_wrap[i] = (m_val[i] == t);
                        m_val[i]  = (m_val[i] + (up ? 1 : modv[i] - 1)) % modv[i];
                    end
                end
            end
        end
    endtask

    task automatic checkDut(input int i, input int v, input int w, input int d);
        checkOutput($sformatf("val[%0d]", i), v, m_val[i]);
        checkOutput($sformatf("wrap[%0d]", i), w, int'(m_wrap[i]));
        checkOutput($sformatf("done[%0d]", i), d, int'(m_done[i]));
    endtask

    task automatic applyStimulus(input bit r, input bit c, input bit u, input bit o,
                                 input bit l, input int lv);
        @(negedge clk);
        rst = r; cen = c; up = u; oneshot = o; ld = l; ld_val = 8'(lv);
        #1;
        checkOutput("tc[0]", int'(tc_a), int'(modelQen(0) && m_val[0] == modelTerm(0)));
        checkOutput("tc[1]", int'(tc_b), int'(modelQen(1) && m_val[1] == modelTerm(1)));
        checkOutput("tc[2]", int'(tc_c), int'(modelQen(2) && m_val[2] == modelTerm(2)));
        @(posedge clk);
        modelUpdate();
        #1;
        checkDut(0, int'(val_a), int'(wrap_a), int'(done_a));
        checkDut(1, int'(val_b), int'(wrap_b), int'(done_b));
        checkDut(2, int'(val_c), int'(wrap_c), int'(done_c));
    endtask

    initial begin
        bit cur_up;
        bit cur_os;

        // Reset, then free-run up through a full wrap of the 8-bit counter.
        repeat (2) applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("reset_val", int'(val_a), 0);
        repeat (260) applyStimulus(1, 1, 1, 0, 0, 0);
`ifndef BIN_COUNT_PRESCALE_EN
        checkOutput("count260_val", int'(val_a), 4);
`endif

        // Down count through zero on the mod-10 counter.
        applyStimulus(1, 0, 0, 0, 1, 3);
        repeat (6) applyStimulus(1, 1, 0, 0, 0, 0);
`ifndef BIN_COUNT_PRESCALE_EN
        checkOutput("down_val_b", int'(val_b), 7);
`endif

        // One-shot up from 7, then reload.
        applyStimulus(1, 0, 1, 1, 1, 7);
        repeat (5) applyStimulus(1, 1, 1, 1, 0, 0);
`ifndef BIN_COUNT_PRESCALE_EN
        checkOutput("oneshot_done_b", int'(done_b), 1);
        checkOutput("oneshot_hold_b", int'(val_b), 9);
`endif
        repeat (3) applyStimulus(1, 1, 1, 0, 0, 0);
        applyStimulus(1, 1, 1, 1, 1, 2);
        checkOutput("reload_val_b", int'(val_b), 2);

        // Load clamp beats enable; reset beats load.
        applyStimulus(1, 1, 1, 0, 1, 12);
        checkOutput("clamp_b", int'(val_b), 9);
        applyStimulus(0, 1, 1, 0, 1, 12);
        checkOutput("rst_over_ld_a", int'(val_a), 0);

        // Reset mid-count, then in DONE.
        repeat (5) applyStimulus(1, 1, 1, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0, 0);
        repeat (4) applyStimulus(1, 1, 1, 0, 0, 0);
        applyStimulus(1, 0, 1, 1, 1, 8);
        repeat (12) applyStimulus(1, 1, 1, 1, 0, 0);
        applyStimulus(0, 1, 1, 1, 0, 0);
        checkOutput("rst_done_b", int'(done_b), 0);
        repeat (2) applyStimulus(1, 1, 1, 0, 0, 0);

        // Enable gaps and a mid-window load, which matter when prescaling.
        repeat (6) applyStimulus(1, 1, 1, 0, 0, 0);
        repeat (3) applyStimulus(1, 0, 1, 0, 0, 0);
        repeat (6) applyStimulus(1, 1, 1, 0, 0, 0);
        applyStimulus(1, 1, 1, 0, 1, 1);
        repeat (9) applyStimulus(1, 1, 1, 0, 0, 0);

        // Random traffic.
        cur_up = 1'b1;
        cur_os = 1'b0;
        repeat (1500) begin
            if ($urandom_range(0, 9) == 0) cur_up = ~cur_up;
            if ($urandom_range(0, 19) == 0) cur_os = ~cur_os;
            applyStimulus($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0, cur_up, cur_os,
                          $urandom_range(0, 15) == 0, int'($urandom_range(0, 255)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bin_count_mod.md
# bin_count_mod

Parametrised modulo up/down binary counter: the next generation of the team's 8-bit enable counter. It adds configurable width and modulus, direction control, synchronous load, a one-shot (stop-at-terminal) mode, a terminal-count flag and a registered wrap pulse. It is used as a general timebase, event counter or divider in lab designs, driven from the board clock.

## Interface
- `WIDTH`, default 8: counter width in bits.
- `MODULUS`, default 256: count range is 0..MODULUS-1. Legal values are 2 ≤ MODULUS ≤ 2^WIDTH; an elaboration-time check flags any other value.
- `PRESCALE`, default 4: qualified enables per count step. Legal values are ≥ 1. Used only under `BIN_COUNT_PRESCALE_EN`.
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: reset, synchronous, active-low.
- `cen`, in, 1: count enable.
- `up`, in, 1: direction; 1 = increment, 0 = decrement. Sampled on every active cycle.
- `oneshot`, in, 1: 1 = stop at the terminal value instead of wrapping.
- `ld`, in, 1: synchronous load strobe.
- `ld_val`, in, WIDTH: load value.
- `val`, out, WIDTH: registered count.
- `tc`, out, 1: combinational terminal-count flag.
- `wrap`, out, 1: registered one-cycle pulse, asserted the cycle after `val` wraps.
- `done`, out, 1: registered; high while in one-shot DONE.

## Operation
- Priority each rising edge: `rst` low, then `ld`, then qualified `cen`, then hold.
- **Reset** (`rst`=0): `val`=0, `wrap`=0, `done`=0, state RUN, prescaler=0.
- **Load** (`ld`=1):
  - `val` ← `ld_val`; if `ld_val` ≥ MODULUS, `val` ← MODULUS-1 (clamp).
  - State → RUN, `done`=0, `wrap`=0, prescaler cleared. `cen` is ignored that cycle.
- **Terminal value** T: MODULUS-1 when `up`=1, 0 when `up`=0.
- **Step**, taken when the state is RUN and the enable is qualified:
  - If `val` ≠ T: `val` ← `val`±1.
  - If `val` = T and `oneshot`=0: `val` wraps to 0 (up) or MODULUS-1 (down). `wrap`=1 for the next cycle only.
  - If `val` = T and `oneshot`=1: `val` holds and the state goes to DONE with `done`=1. No `wrap` pulse.
- **State machine**, two states:
  - RUN → DONE on a one-shot terminal step.
  - DONE → RUN on `ld` or reset.
  - Clearing `oneshot` while in DONE does not leave DONE.
- **`tc`** = (`val` = T) ∧ qualified enable ∧ (state = RUN). It is high exactly in the cycle whose edge wraps or finishes the count.
- **Arithmetic**: all comparisons are at WIDTH bits. MODULUS = 2^WIDTH must wrap naturally, with no WIDTH+1-bit overflow.
- **Direction change**: a change of `up` mid-count takes effect on the next step. T is re-evaluated combinationally.

## Timing
- `val`, `wrap` and `done` change only on rising `clk`.
- Latency from `cen`/`ld` sampled to `val` updated is 1 cycle.
- `wrap` rises 1 cycle after the wrapping edge and lasts exactly 1 cycle. Back-to-back wraps (MODULUS=2, continuous `cen`) give one pulse per wrap.
- `tc` is combinational from `val`, `up`, `cen`, state and the prescaler. No registered delay.
- `rst` held low dominates every other input in that cycle. Reset mid-count or in DONE returns to the reset values on the next edge.

## Configuration
- `BIN_COUNT_PRESCALE_EN` defined:
  - An internal prescaler counts `cen`-high cycles in state RUN.
  - The qualified enable is high only on the PRESCALE-th such cycle, after which the prescaler clears.
  - `cen` low holds the prescaler.
  - `ld` and `rst` clear the prescaler.
  - PRESCALE=1 behaves identically to the undefined case.
- `BIN_COUNT_PRESCALE_EN` undefined: the qualified enable equals `cen`, no prescaler logic is built, and `PRESCALE` is ignored.

## Test plan
- **Reset and count:** WIDTH=8, MODULUS=256; `rst` low 2 cycles, then `cen`=1, `up`=1 for 260 cycles.
  - `val`=0 during reset.
  - `val` counts 0..255, then 0..3.
  - `tc` high only at `val`=255.
  - `wrap`=1 in the single cycle with `val`=0 after wrap.
- **Non-power-of-two, down count:** MODULUS=10, `ld_val`=3, `up`=0, `cen`=1 for 6 cycles.
  - `val` sequence 3,2,1,0,9,8.
  - `tc` high at `val`=0.
  - One `wrap` pulse.
- **One-shot:** MODULUS=10, `oneshot`=1, load 7, count up.
  - `val` 7,8,9, then holds 9 with `done`=1 and no `wrap`.
  - `cen` ignored in DONE.
  - `ld` with `ld_val`=2 gives `val`=2, `done`=0.
- **Load priority and clamp:**
  - `ld`=1, `cen`=1 together with `ld_val`=12, MODULUS=10 → `val`=9, no step that cycle.
  - `rst`=0 with `ld`=1 → `val`=0.
- **Reset mid-operation:** `rst` pulsed low 1 cycle at `val`=5 while counting, and again in DONE → `val`=0, `done`=0, `wrap`=0 next edge; counting resumes at 1.
- **Prescale (`BIN_COUNT_PRESCALE_EN`, PRESCALE=4):** `cen`=1 continuously → `val` steps every 4th cycle.
  - `cen` dropped for 3 cycles mid-window → step delayed by exactly 3 cycles.
  - `ld` mid-window → prescaler restarts; next step 4 `cen` cycles later.
